i4002_vfd_scan: RTL and testbench

Multiplexed VFD scan controller for the working-register display. It reads the 16 main and 4 status characters of one i4002 RAM register through that RAM's second read port (`addr2`/`data2_out`). It drives one digit grid at a time with hex-decoded segments and a blanking gap between digits. Status characters are captured once per frame as annunciator bits.

---
 rtl/i4002_vfd_scan_if.sv | 33 +++
 rtl/i4002_vfd_scan.sv | 214 +++++++++++++++++++++
 tb/tb_i4002_vfd_scan.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i4002_vfd_scan_if.sv
// Signal bundle between the VFD scan controller, the i4002 RAM second read port
// and the display driver. The controller is the master.
interface i4002_vfd_scan_if #(
  parameter int DIGITS = 16
);
  logic              enable;
  logic [4:0]        ram_addr2;
  logic [3:0]        ram_data2;
  logic [DIGITS-1:0] grid;
  logic [6:0]        seg;
  logic [15:0]       ann;
  logic              frame_done;

  modport master (
    input  enable,
    input  ram_data2,
    output ram_addr2,
    output grid,
    output seg,
    output ann,
    output frame_done
  );

  modport slave (
    output enable,
    output ram_data2,
    input  ram_addr2,
    input  grid,
    input  seg,
    input  ann,
    input  frame_done
  );
endinterface

// File: rtl/i4002_vfd_scan.sv
// Multiplexed VFD scan controller: walks the main characters of one i4002 RAM
// register digit by digit, then latches the four status characters as annunciators.
module i4002_vfd_scan #(
  parameter int DIGITS = 16,
  parameter int DWELL  = 2000,
  parameter int BLANK  = 100
) (
  input  logic             sysclk,
  input  logic             poc_n,
  i4002_vfd_scan_if.master bus
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHOW,
    S_GAP,
    S_STAT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_sidx;
  logic [4:0]        r_addr;
  logic [DIGITS-1:0] r_grid;
  logic [6:0]        r_seg;
  logic [15:0]       r_ann;
  logic              r_fd;

  logic [IW-1:0]     w_idx_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [1:0]        w_sidx_nxt;
  logic [4:0]        w_addr_nxt;
  logic [DIGITS-1:0] w_grid_nxt;
  logic [6:0]        w_seg_nxt;
  logic [15:0]       w_ann_nxt;
  logic              w_fd_nxt;

  logic              w_cnt_zero;
  logic              w_last_digit;
  logic              w_step;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_cnt_zero   = (r_cnt == '0);
  assign w_last_digit = (r_idx == IDX_LAST);
  // A digit slot ends at the bottom of GAP, or straight out of SHOW when there is no gap.
  assign w_step       = w_cnt_zero &&
                        ((r_state == S_GAP) || ((r_state == S_SHOW) && (BLANK == 0)));

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FETCH;
        S_FETCH: w_state_nxt = S_SHOW;
        S_SHOW: begin
          if (w_cnt_zero) begin
            if (BLANK > 0)         w_state_nxt = S_GAP;
            else if (w_last_digit) w_state_nxt = S_STAT;
            else                   w_state_nxt = S_FETCH;
          end
        end
        S_GAP: begin
          if (w_cnt_zero) w_state_nxt = w_last_digit ? S_STAT : S_FETCH;
        end
        S_STAT: begin
          if (r_sidx == 2'd3) w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_sidx_nxt = r_sidx;
    w_addr_nxt = r_addr;
    w_grid_nxt = r_grid;
    w_seg_nxt  = r_seg;
    w_ann_nxt  = r_ann;
    w_fd_nxt   = 1'b0;

    if (!bus.enable) begin
      w_idx_nxt  = '0;
      w_cnt_nxt  = '0;
      w_sidx_nxt = '0;
      w_addr_nxt = '0;
      w_grid_nxt = '0;
      w_seg_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_idx_nxt  = '0;
          w_addr_nxt = '0;
        end
        S_FETCH: begin
          w_seg_nxt         = hex7(bus.ram_data2);
          w_grid_nxt        = '0;
          w_grid_nxt[r_idx] = 1'b1;
          w_cnt_nxt         = DWELL_LD;
        end
        S_SHOW: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_grid_nxt = '0;
            if (BLANK > 0) w_cnt_nxt = BLANK_LD;
          end
        end
        S_GAP: begin
          if (!w_cnt_zero) w_cnt_nxt = r_cnt - CW'(1);
        end
        S_STAT: begin
          // The address was already pointed at this status character one edge earlier.
          w_ann_nxt[{r_sidx, 2'b00} +: 4] = bus.ram_data2;
          w_sidx_nxt = r_sidx + 2'd1;
          if (r_sidx == 2'd3) begin
            w_addr_nxt = '0;
            w_idx_nxt  = '0;
            w_fd_nxt   = 1'b1;
          end else begin
            w_addr_nxt = 5'd17 + 5'(r_sidx);
          end
        end
        default: begin
          w_grid_nxt = '0;
        end
      endcase

      if (w_step) begin
        if (!w_last_digit) begin
          w_idx_nxt  = r_idx + IW'(1);
          w_addr_nxt = 5'(r_idx) + 5'd1;
        end else begin
          w_addr_nxt = 5'd16;
          w_sidx_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_sidx <= '0;
      r_addr <= '0;
      r_grid <= '0;
      r_seg  <= '0;
      r_ann  <= '0;
      r_fd   <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_cnt  <= w_cnt_nxt;
      r_sidx <= w_sidx_nxt;
      r_addr <= w_addr_nxt;
      r_grid <= w_grid_nxt;
      r_seg  <= w_seg_nxt;
      r_ann  <= w_ann_nxt;
      r_fd   <= w_fd_nxt;
    end
  end

  assign bus.ram_addr2  = r_addr;
  assign bus.grid       = r_grid;
  assign bus.seg        = r_seg;
  assign bus.ann        = r_ann;
  assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_i4002_vfd_scan.sv
// Bench for i4002_vfd_scan: one instance with a blanking gap, one without, each
// reading its own RAM model, checked against a frame-position reference model.
module tb_i4002_vfd_scan;

  localparam int DIGITS  = 4;
  localparam int DWELL   = 3;
  localparam int BLANK_A = 1;
  localparam int BLANK_B = 0;

  logic sysclk = 1'b0;
  logic poc_n  = 1'b0;
  int   cmp    = 0;
  int   fails  = 0;

  logic [3:0] mem [2][32];
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: position within the frame, counted from the first FETCH cycle.
  bit              run   [2];
  int              tf    [2];
  logic [DIGITS-1:0] e_grid [2];
  logic [6:0]      e_seg  [2];
  logic [4:0]      e_addr [2];
  logic [15:0]     e_ann  [2];
  logic            e_fd   [2];

  i4002_vfd_scan_if #(.DIGITS(DIGITS)) bus_a ();
  i4002_vfd_scan_if #(.DIGITS(DIGITS)) bus_b ();

  assign bus_a.ram_data2 = mem[0][bus_a.ram_addr2];
  assign bus_b.ram_data2 = mem[1][bus_b.ram_addr2];

  i4002_vfd_scan #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK_A)) dut_a (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (bus_a.master)
  );

  i4002_vfd_scan #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK_B)) dut_b (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (bus_b.master)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic int period(input int u);
    return 1 + DWELL + ((u == 0) ? BLANK_A : BLANK_B);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      run[u]    = 1'b0;
      tf[u]     = 0;
      e_grid[u] = '0;
      e_seg[u]  = '0;
      e_addr[u] = '0;
      e_ann[u]  = '0;
      e_fd[u]   = 1'b0;
    end
  endtask

  // Advance unit u across one rising edge, using the inputs that were present before it.
  task automatic model_step(input int u);
    int   p, nd, d, o, j;
    logic en;
    en = (u == 0) ? bus_a.enable : bus_b.enable;
    p  = period(u);
    nd = DIGITS * p;
    if (!poc_n) return;
    if (!en) begin
      run[u]    = 1'b0;
      tf[u]     = 0;
      e_grid[u] = '0;
      e_seg[u]  = '0;
      e_addr[u] = '0;
      e_fd[u]   = 1'b0;
      return;
    end
    if (!run[u]) begin
      run[u]  = 1'b1;
      tf[u]   = 0;
      e_fd[u] = 1'b0;
    end else begin
      if (tf[u] < nd) begin
        if (tf[u] % p == 0) e_seg[u] = font[mem[u][tf[u] / p]];
      end else begin
        j = tf[u] - nd;
        e_ann[u][4*j +: 4] = mem[u][16 + j];
      end
      tf[u]   = tf[u] + 1;
      e_fd[u] = 1'b0;
      if (tf[u] == nd + 4) begin
        tf[u]   = 0;
        e_fd[u] = 1'b1;
      end
    end
    if (tf[u] < nd) begin
      d = tf[u] / p;
      o = tf[u] % p;
      e_addr[u] = 5'(d);
      e_grid[u] = (o >= 1 && o <= DWELL) ? (DIGITS'(1) << d) : '0;
    end else begin
      e_addr[u] = 5'(16 + tf[u] - nd);
      e_grid[u] = '0;
    end
  endtask

  task automatic cycle();
    @(posedge sysclk);
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic run_until(input int u, input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (run[u] && tf[u] == target) begin
        ok = 1'b1;
        return;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 32; a++) begin
      mem[0][a] = 4'h0;
      mem[1][a] = 4'($urandom);
    end
    for (int a = 0; a < 4; a++) begin
      mem[0][a]      = 4'(a + 1);
      mem[0][16 + a] = 4'(4'hA + a);
    end
    model_reset();
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b0;
    poc_n = 1'b0;
    #3;
    cmp++;
    if ({bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_a got grid=%b seg=%h addr=%0d ann=%h fd=%b want all zero",
               bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done);
    end
    bus_a.enable = 1'b1;
    bus_b.enable = 1'b1;
    cycle();
    cycle();
    cmp++;
    if ({bus_b.grid, bus_b.seg, bus_b.ram_addr2, bus_b.ann, bus_b.frame_done} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_hold_b got grid=%b seg=%h addr=%0d ann=%h fd=%b want all zero",
               bus_b.grid, bus_b.seg, bus_b.ram_addr2, bus_b.ann, bus_b.frame_done);
    end
    poc_n = 1'b1;
  endtask

  task automatic test_scan();
    int first_fd, second_fd;
    first_fd  = -1;
    second_fd = -1;
    for (int i = 1; i <= 49; i++) begin
      cycle();
      cmp++;
      if ({bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done} !==
          {e_grid[0], e_seg[0], e_addr[0], e_ann[0], e_fd[0]}) begin
        fails++;
        $display("[TB] FAIL scan_a cyc=%0d got grid=%b seg=%h addr=%0d ann=%h fd=%b want grid=%b seg=%h addr=%0d ann=%h fd=%b",
                 i, bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done,
                 e_grid[0], e_seg[0], e_addr[0], e_ann[0], e_fd[0]);
      end
      cmp++;
      if (!$onehot0(bus_a.grid)) begin
        fails++;
        $display("[TB] FAIL onehot_a cyc=%0d got grid=%b want at most one bit", i, bus_a.grid);
      end
      if (bus_a.frame_done === 1'b1) begin
        if (first_fd < 0) first_fd = i;
        else if (second_fd < 0) second_fd = i;
      end
    end
    cmp++;
    if (bus_a.ann !== 16'hDCBA) begin
      fails++;
      $display("[TB] FAIL ann_first_frame got %h want DCBA", bus_a.ann);
    end
    cmp++;
    if (first_fd != 25 || second_fd != 49) begin
      fails++;
      $display("[TB] FAIL frame_period_a got pulses at %0d,%0d want 25,49", first_fd, second_fd);
    end
  endtask

  task automatic test_no_blank();
    int last_fd, prev_fd;
    last_fd = -1;
    prev_fd = -1;
    for (int i = 0; i < 45; i++) begin
      cycle();
      cmp++;
      if ({bus_b.grid, bus_b.seg, bus_b.ram_addr2, bus_b.ann, bus_b.frame_done} !==
          {e_grid[1], e_seg[1], e_addr[1], e_ann[1], e_fd[1]}) begin
        fails++;
        $display("[TB] FAIL noblank_b cyc=%0d got grid=%b seg=%h addr=%0d ann=%h fd=%b want grid=%b seg=%h addr=%0d ann=%h fd=%b",
                 i, bus_b.grid, bus_b.seg, bus_b.ram_addr2, bus_b.ann, bus_b.frame_done,
                 e_grid[1], e_seg[1], e_addr[1], e_ann[1], e_fd[1]);
      end
      cmp++;
      if (!$onehot0(bus_b.grid)) begin
        fails++;
        $display("[TB] FAIL onehot_b cyc=%0d got grid=%b want at most one bit", i, bus_b.grid);
      end
      if (bus_b.frame_done === 1'b1) begin
        prev_fd = last_fd;
        last_fd = i;
      end
    end
    cmp++;
    if (prev_fd < 0 || last_fd - prev_fd != 20) begin
      fails++;
      $display("[TB] FAIL frame_period_b got pulses at %0d,%0d want spacing 20", prev_fd, last_fd);
    end
  endtask

  task automatic test_ram_write();
    bit ok;
    run_until(0, 6, ok);
    mem[0][2] = 4'hF;
    run_until(0, 11, ok);
    cmp++;
    if (!ok || bus_a.seg !== 7'h71 || bus_a.grid !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL write_ahead ok=%0b got seg=%h grid=%b want seg=71 grid=0100", ok, bus_a.seg, bus_a.grid);
    end
    run_until(0, 16, ok);
    mem[0][0] = 4'h8;
    cycle();
    cmp++;
    if (!ok || bus_a.seg !== 7'h66 || bus_a.grid !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL write_behind_same ok=%0b got seg=%h grid=%b want seg=66 grid=1000", ok, bus_a.seg, bus_a.grid);
    end
    run_until(0, 1, ok);
    cmp++;
    if (!ok || bus_a.seg !== 7'h7F || bus_a.grid !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL write_behind_next ok=%0b got seg=%h grid=%b want seg=7f grid=0001", ok, bus_a.seg, bus_a.grid);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int idle;
    logic [15:0] kept;
    run_until(0, 12, ok);
    kept = e_ann[0];
    bus_a.enable = 1'b0;
    cycle();
    cmp++;
    if (!ok || {bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.frame_done} !== '0 || bus_a.ann !== kept) begin
      fails++;
      $display("[TB] FAIL enable_drop ok=%0b got grid=%b seg=%h addr=%0d fd=%b ann=%h want zeros ann=%h",
               ok, bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.frame_done, bus_a.ann, kept);
    end
    idle = $urandom_range(2, 6);
    for (int i = 0; i < idle; i++) begin
      cycle();
      cmp++;
      if ({bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done} !==
          {e_grid[0], e_seg[0], e_addr[0], e_ann[0], e_fd[0]}) begin
        fails++;
        $display("[TB] FAIL idle_a cyc=%0d got grid=%b seg=%h addr=%0d fd=%b want grid=%b seg=%h addr=%0d fd=%b",
                 i, bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.frame_done,
                 e_grid[0], e_seg[0], e_addr[0], e_fd[0]);
      end
    end
    bus_a.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      cmp++;
      if ({bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done} !==
          {e_grid[0], e_seg[0], e_addr[0], e_ann[0], e_fd[0]}) begin
        fails++;
        $display("[TB] FAIL restart_a cyc=%0d got grid=%b seg=%h addr=%0d fd=%b want grid=%b seg=%h addr=%0d fd=%b",
                 i, bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.frame_done,
                 e_grid[0], e_seg[0], e_addr[0], e_fd[0]);
      end
      if (i == 1) begin
        cmp++;
        if (bus_a.grid !== 4'b0001 || bus_a.seg !== font[mem[0][0]]) begin
          fails++;
          $display("[TB] FAIL restart_digit0 got grid=%b seg=%h want grid=0001 seg=%h",
                   bus_a.grid, bus_a.seg, font[mem[0][0]]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stat();
    bit ok;
    run_until(0, 21, ok);
    #2;
    poc_n = 1'b0;
    #1;
    cmp++;
    if (!ok || {bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_stat ok=%0b got grid=%b seg=%h addr=%0d ann=%h fd=%b want all zero",
               ok, bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done);
    end
    model_reset();
    cycle();
    cycle();
    poc_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      cmp++;
      if ({bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done} !==
          {e_grid[0], e_seg[0], e_addr[0], e_ann[0], e_fd[0]}) begin
        fails++;
        $display("[TB] FAIL post_reset_a cyc=%0d got grid=%b seg=%h addr=%0d ann=%h fd=%b want grid=%b seg=%h addr=%0d ann=%h fd=%b",
                 i, bus_a.grid, bus_a.seg, bus_a.ram_addr2, bus_a.ann, bus_a.frame_done,
                 e_grid[0], e_seg[0], e_addr[0], e_ann[0], e_fd[0]);
      end
      if (i == 1) begin
        cmp++;
        if (bus_a.grid !== 4'b0001) begin
          fails++;
          $display("[TB] FAIL post_reset_digit0 got grid=%b want 0001", bus_a.grid);
        end
      end
    end
  endtask

  task automatic test_font_sweep();
    bit ok;
    int perm [16];
    int r, t;
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      r = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[r];
      perm[r] = t;
    end
    for (int f = 0; f < 4; f++) begin
      run_until(0, 0, ok);
      for (int d = 0; d < 4; d++) mem[0][d] = 4'(perm[4*f + d]);
      for (int d = 0; d < 4; d++) begin
        run_until(0, d * period(0) + 1, ok);
        cmp++;
        if (!ok || bus_a.seg !== font[perm[4*f + d]] || bus_a.grid !== (4'b0001 << d)) begin
          fails++;
          $display("[TB] FAIL font_%0h ok=%0b got seg=%h grid=%b want seg=%h grid=%b",
                   perm[4*f + d], ok, bus_a.seg, bus_a.grid, font[perm[4*f + d]], 4'b0001 << d);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_scan();
    test_no_blank();
    test_ram_write();
    test_enable_drop();
    test_reset_mid_stat();
    test_font_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp, fails);
    $finish;
  end

endmodule
